// File: rtl/colour_pkg.sv
// Shared types and the default iteration-to-colour mapping for iter_colour_map.
package colour_pkg;

    localparam int X_SIZE = 640;
    localparam int Y_SIZE = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Only iter[7:0] reaches the colour stage; the full count is consumed by in_set at accept.
    typedef struct packed {
        logic [7:0] iter;
        logic       in_set;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    function automatic rgb_t iter_to_rgb(input logic [7:0] iter);
        rgb_t c;
        c.r = iter;
        c.g = {iter[5:0], 2'b00};
        c.b = ~iter;
        return c;
    endfunction

endpackage

// File: rtl/iter_colour_map_if.sv
// Iteration-in / colour-out stream bundle; master is the upstream+downstream environment, slave is the colour stage.
interface iter_colour_map_if #(
    parameter int MAX_ITER_WIDTH = 16
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [MAX_ITER_WIDTH-1:0] iter_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [7:0]                r_o;
    logic [7:0]                g_o;
    logic [7:0]                b_o;
    logic                      sof_o;
    logic                      eol_o;

    modport master (
        output in_valid_i, iter_i, out_ready_i,
        input  in_ready_o, out_valid_o, r_o, g_o, b_o, sof_o, eol_o
    );

    modport slave (
        input  in_valid_i, iter_i, out_ready_i,
        output in_ready_o, out_valid_o, r_o, g_o, b_o, sof_o, eol_o
    );
endinterface

// File: rtl/colour_palette_ram.sv
// 256x24 palette RAM: one write port, one synchronous read-first read port.
module colour_palette_ram (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [7:0]  waddr_i,
    input  logic [23:0] wdata_i,
    input  logic        re_i,
    input  logic [7:0]  raddr_i,
    output logic [23:0] rdata_o
);

    logic [23:0] mem [256];

    // NOTE: no reset on the array or read register so this maps onto block RAM; the
    // non-blocking read sees the pre-write contents on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/iter_colour_map.sv
// Two-stage iteration-count to RGB stream stage with raster tagging and backpressure.
// Define COLOUR_LUT_EN to replace the arithmetic mapping with a writable 256x24 palette.
module iter_colour_map
    import colour_pkg::*;
#(
    parameter int MAX_ITER_WIDTH = 16,
    parameter int X_SIZE         = colour_pkg::X_SIZE,
    parameter int Y_SIZE         = colour_pkg::Y_SIZE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
    input  logic                      frame_restart_i,
    iter_colour_map_if.slave          s,
    output logic                      frame_done_o
`ifdef COLOUR_LUT_EN
    ,
    input  logic                      pal_we_i,
    input  logic [7:0]                pal_addr_i,
    input  logic [23:0]               pal_data_i
`endif
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic          en, accept;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          x_last, y_last;
    beat_t         s1_q;
    logic          v1_q, v2_q;
    logic          sof2_q, eol2_q, eof2_q;
    rgb_t          colour;

    // A stalled output freezes both stages together, so bubbles stay where they are.
    assign en         = ~v2_q | s.out_ready_i;
    assign accept     = s.in_valid_i & en;
    assign s.in_ready_o = en;
    assign x_last     = (x_q == X_LAST);
    assign y_last     = (y_q == Y_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (frame_restart_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (en) begin
            v1_q <= accept;
            if (accept) begin
                s1_q.iter   <= s.iter_i[7:0];
                s1_q.in_set <= (s.iter_i >= max_iter_i);
                s1_q.sof    <= (x_q == '0) && (y_q == '0);
                s1_q.eol    <= x_last;
                s1_q.eof    <= x_last && y_last;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2_q   <= 1'b0;
            sof2_q <= 1'b0;
            eol2_q <= 1'b0;
            eof2_q <= 1'b0;
        end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sof2_q <= s1_q.sof;
                eol2_q <= s1_q.eol;
                eof2_q <= s1_q.eof;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) frame_done_o <= 1'b0;
        else       frame_done_o <= v2_q & s.out_ready_i & eof2_q;
    end

`ifdef COLOUR_LUT_EN
    rgb_t pal_q;
    logic set2_q;

    // The read is issued from stage 1 so the RAM output register doubles as stage 2.
    colour_palette_ram u_palette (
        .clk_i   (clk_i),
        .we_i    (pal_we_i),
        .waddr_i (pal_addr_i),
        .wdata_i (pal_data_i),
        .re_i    (en & v1_q),
        .raddr_i (s1_q.iter),
        .rdata_o (pal_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          set2_q <= 1'b1;
        else if (en & v1_q) set2_q <= s1_q.in_set;
    end

    assign colour = (v2_q & ~set2_q) ? pal_q : '0;
`else
    rgb_t rgb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          rgb_q <= '0;
        else if (en & v1_q) rgb_q <= s1_q.in_set ? '0 : iter_to_rgb(s1_q.iter);
    end

    assign colour = rgb_q;
`endif

    assign s.out_valid_o = v2_q;
    assign s.r_o         = colour.r;
    assign s.g_o         = colour.g;
    assign s.b_o         = colour.b;
    assign s.sof_o       = sof2_q;
    assign s.eol_o       = eol2_q;

endmodule
